mem_write_arbiter: RTL and testbench

MEM_WRITE_ARBITER -- requirements
Module: mem_write_arbiter

---
 rtl/mem_write_arbiter.sv | 151 +++++++++++++++
 tb/tb_mem_write_arbiter.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_write_arbiter.sv
// Merges CPU, downloader and eraser byte writes onto the ROM/RAM dpram write ports.
// Optional ARB_DROP_COUNT_EN adds a saturating drop_count output.
module mem_write_arbiter #(
    parameter int FIFO_DEPTH = 4
) (
    input  logic        clk_sys,
    input  logic        reset_n,
    input  logic        dl_active,
    input  logic        dl_wr,
    input  logic [24:0] dl_addr,
    input  logic [7:0]  dl_data,
    input  logic        er_active,
    input  logic        er_wr,
    input  logic [24:0] er_addr,
    input  logic [7:0]  er_data,
    input  logic        cpu_wr,
    input  logic [15:0] cpu_addr,
    input  logic [7:0]  cpu_data,
    input  logic        rom_enabled,
    output logic        rom_wr,
    output logic [14:0] rom_addr,
    output logic [7:0]  rom_data,
    output logic        ram_wr,
    output logic [15:0] ram_addr,
    output logic [7:0]  ram_data,
    output logic        ld_ready,
    output logic        ld_overflow,
`ifdef ARB_DROP_COUNT_EN
    output logic [15:0] drop_count,
`endif
    output logic        busy
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam logic [PTR_W:0] FULL_CNT = (PTR_W+1)'(FIFO_DEPTH);

    typedef enum logic [1:0] {IDLE, LOAD, ERASE, DRAIN} state_t;

    state_t            state;
    logic [32:0]       fifo_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [PTR_W:0]    count;
    logic [PTR_W:0]    count_next;

    logic        push_req;
    logic [32:0] push_entry;
    logic        push_ok;
    logic        push_lost;
    logic        pop;
    logic        fifo_full;
    logic        cpu_accept;
    logic [24:0] head_addr;
    logic [7:0]  head_data;
    logic        head_is_rom;
    logic        head_is_ram;

    always_comb begin
        push_req    = (state == LOAD && dl_wr) || (state == ERASE && er_wr);
        push_entry  = (state == LOAD) ? {dl_addr, dl_data} : {er_addr, er_data};
        cpu_accept  = cpu_wr && (!rom_enabled || cpu_addr[15]);
        fifo_full   = (count == FULL_CNT);
        // A CPU write owns the output ports this cycle, so the FIFO head waits.
        pop         = (count != '0) && !cpu_accept;
        push_ok     = push_req && (!fifo_full || pop);
        push_lost   = push_req && !push_ok;
        count_next  = count + {{PTR_W{1'b0}}, push_ok} - {{PTR_W{1'b0}}, pop};
        {head_addr, head_data} = fifo_mem[rd_ptr];
        head_is_rom = (head_addr < 25'h0008000);
        head_is_ram = (head_addr[24:16] == 9'h001);
    end

    assign busy = (state != IDLE);

`ifdef ARB_DROP_COUNT_EN
    logic       cpu_drop;
    logic       oob_pop;
    logic [1:0] drop_inc;

    function automatic logic [15:0] sat_add16(input logic [15:0] cnt, input logic [1:0] inc);
        logic [16:0] sum;
        sum = {1'b0, cnt} + {15'd0, inc};
        return sum[16] ? 16'hFFFF : sum[15:0];
    endfunction

    always_comb begin
        cpu_drop = cpu_wr && !cpu_accept;
        oob_pop  = pop && !head_is_rom && !head_is_ram;
        drop_inc = {1'b0, cpu_drop} + {1'b0, oob_pop} + {1'b0, push_lost};
    end

    always_ff @(posedge clk_sys) begin
        if (!reset_n) drop_count <= '0;
        else          drop_count <= sat_add16(drop_count, drop_inc);
    end
`endif

    // FIFO storage holds data only; occupancy is tracked by the pointers and count.
    always_ff @(posedge clk_sys) begin
        if (push_ok) fifo_mem[wr_ptr] <= push_entry;
    end

    always_ff @(posedge clk_sys) begin
        if (!reset_n) begin
            state       <= IDLE;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            count       <= '0;
            rom_wr      <= 1'b0;
            rom_addr    <= '0;
            rom_data    <= '0;
            ram_wr      <= 1'b0;
            ram_addr    <= '0;
            ram_data    <= '0;
            ld_ready    <= 1'b1;
            ld_overflow <= 1'b0;
        end else begin
            case (state)
                IDLE:    if (dl_active) state <= LOAD;
                         else if (er_active) state <= ERASE;
                LOAD:    if (!dl_active) state <= DRAIN;
                ERASE:   if (!er_active) state <= DRAIN;
                DRAIN:   if (count == '0) state <= IDLE;
                default: state <= IDLE;
            endcase

            if (push_ok) wr_ptr <= wr_ptr + 1'b1;
            if (pop)     rd_ptr <= rd_ptr + 1'b1;
            count       <= count_next;
            ld_ready    <= (count_next != FULL_CNT);
            ld_overflow <= ld_overflow | push_lost;

            rom_wr <= 1'b0;
            ram_wr <= 1'b0;
            if (cpu_accept) begin
                ram_wr   <= 1'b1;
                ram_addr <= cpu_addr;
                ram_data <= cpu_data;
            end else if (pop && head_is_rom) begin
                rom_wr   <= 1'b1;
                rom_addr <= head_addr[14:0];
                rom_data <= head_data;
            end else if (pop && head_is_ram) begin
                ram_wr   <= 1'b1;
                ram_addr <= head_addr[15:0];
                ram_data <= head_data;
            end
        end
    end

endmodule

// File: tb/tb_mem_write_arbiter.sv
// Randomized plus directed bench for mem_write_arbiter against a queue-based reference model.
module tb_mem_write_arbiter;

    localparam int DEPTH = 4;

    logic        clk_sys = 1'b0;
    logic        reset_n;
    logic        dl_active, dl_wr, er_active, er_wr, cpu_wr, rom_enabled;
    logic [24:0] dl_addr, er_addr;
    logic [7:0]  dl_data, er_data, cpu_data;
    logic [15:0] cpu_addr;
    logic        rom_wr, ram_wr, ld_ready, ld_overflow, busy;
    logic [14:0] rom_addr;
    logic [15:0] ram_addr;
    logic [7:0]  rom_data, ram_data;
`ifdef ARB_DROP_COUNT_EN
    logic [15:0] drop_count;
`endif

    int checks = 0;
    int failures = 0;

    mem_write_arbiter #(.FIFO_DEPTH(DEPTH)) dut (
        .clk_sys(clk_sys), .reset_n(reset_n),
        .dl_active(dl_active), .dl_wr(dl_wr), .dl_addr(dl_addr), .dl_data(dl_data),
        .er_active(er_active), .er_wr(er_wr), .er_addr(er_addr), .er_data(er_data),
        .cpu_wr(cpu_wr), .cpu_addr(cpu_addr), .cpu_data(cpu_data), .rom_enabled(rom_enabled),
        .rom_wr(rom_wr), .rom_addr(rom_addr), .rom_data(rom_data),
        .ram_wr(ram_wr), .ram_addr(ram_addr), .ram_data(ram_data),
        .ld_ready(ld_ready), .ld_overflow(ld_overflow),
`ifdef ARB_DROP_COUNT_EN
        .drop_count(drop_count),
`endif
        .busy(busy)
    );

    always #12 clk_sys = ~clk_sys;

    // Reference model: session mode, a plain queue of pending loader writes, expected outputs.
    typedef struct { logic [24:0] a; logic [7:0] d; } ent_t;
    ent_t q[$];
    int   m_mode;  // 0 idle, 1 loading, 2 erasing, 3 draining
    logic e_rom_wr, e_ram_wr, e_ready, e_ovf;
    logic [14:0] e_rom_addr;
    logic [15:0] e_ram_addr;
    logic [7:0]  e_rom_data, e_ram_data;
    int   e_drop;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_edge();
        bit   cpu_ok, do_pop;
        int   sz0;
        ent_t e;
        if (!reset_n) begin
            q.delete();
            m_mode = 0;
            e_rom_wr = 0; e_ram_wr = 0; e_ready = 1; e_ovf = 0; e_drop = 0;
            e_rom_addr = 0; e_rom_data = 0; e_ram_addr = 0; e_ram_data = 0;
            return;
        end
        sz0 = q.size();
        cpu_ok = cpu_wr && (!rom_enabled || cpu_addr >= 16'h8000);
        if (cpu_wr && !cpu_ok) e_drop++;
        do_pop = (sz0 > 0) && !cpu_ok;
        e_rom_wr = 0;
        e_ram_wr = 0;
        if (cpu_ok) begin
            e_ram_wr = 1; e_ram_addr = cpu_addr; e_ram_data = cpu_data;
        end else if (do_pop) begin
            e = q.pop_front();
            if (e.a < 25'h8000) begin
                e_rom_wr = 1; e_rom_addr = e.a[14:0]; e_rom_data = e.d;
            end else if (e.a >= 25'h10000 && e.a <= 25'h1FFFF) begin
                e_ram_wr = 1; e_ram_addr = e.a[15:0]; e_ram_data = e.d;
            end else begin
                e_drop++;
            end
        end
        if ((m_mode == 1 && dl_wr) || (m_mode == 2 && er_wr)) begin
            if (q.size() < DEPTH) begin
                if (m_mode == 1) q.push_back('{dl_addr, dl_data});
                else             q.push_back('{er_addr, er_data});
            end else begin
                e_ovf = 1;
                e_drop++;
            end
        end
        case (m_mode)
            0: m_mode = dl_active ? 1 : (er_active ? 2 : 0);
            1: if (!dl_active) m_mode = 3;
            2: if (!er_active) m_mode = 3;
            default: if (sz0 == 0) m_mode = 0;
        endcase
        e_ready = (q.size() < DEPTH);
        if (e_drop > 16'hFFFF) e_drop = 16'hFFFF;
    endtask

    task automatic check_outputs();
        chk("rom_wr", rom_wr, e_rom_wr);
        chk("ram_wr", ram_wr, e_ram_wr);
        if (e_rom_wr) begin
            chk("rom_addr", rom_addr, e_rom_addr);
            chk("rom_data", rom_data, e_rom_data);
        end
        if (e_ram_wr) begin
            chk("ram_addr", ram_addr, e_ram_addr);
            chk("ram_data", ram_data, e_ram_data);
        end
        chk("ld_ready", ld_ready, e_ready);
        chk("ld_overflow", ld_overflow, e_ovf);
        chk("busy", busy, m_mode != 0);
`ifdef ARB_DROP_COUNT_EN
        chk("drop_count", drop_count, e_drop);
`endif
    endtask

    task automatic step();
        @(posedge clk_sys);
        model_edge();
        #1;
        check_outputs();
    endtask

    function automatic logic [24:0] rand_addr();
        case ($urandom_range(0, 3))
            0, 1:    return 25'($urandom_range(0, 32'h7FFF));
            2:       return 25'h10000 + 25'($urandom_range(0, 32'hFFFF));
            default: return ($urandom_range(0, 1) != 0) ? 25'h8000 + 25'($urandom_range(0, 32'h7FFF))
                                                        : 25'h20000 + 25'($urandom_range(0, 32'hFFFFF));
        endcase
    endfunction

    initial begin
        reset_n = 0; dl_active = 0; dl_wr = 0; er_active = 0; er_wr = 0;
        cpu_wr = 0; rom_enabled = 0; dl_addr = 0; er_addr = 0;
        dl_data = 0; er_data = 0; cpu_addr = 0; cpu_data = 0;
        step();
        step();
        chk("rst_rom_addr", rom_addr, 0);
        chk("rst_ram_addr", ram_addr, 0);
        chk("rst_rom_data", rom_data, 0);
        chk("rst_ram_data", ram_data, 0);
        chk("rst_ready", ld_ready, 1);
        chk("rst_busy", busy, 0);
        reset_n = 1;
        step();

        // Single ROM-area loader write, two edges from strobe to output.
        dl_active = 1;
        step();
        dl_wr = 1; dl_addr = 25'h00010; dl_data = 8'hAB;
        step();
        dl_wr = 0;
        step();
        chk("ld_rom_wr", rom_wr, 1);
        chk("ld_rom_addr", rom_addr, 15'h0010);
        chk("ld_rom_data", rom_data, 8'hAB);

        // RAM-area write followed by an out-of-range address.
        dl_wr = 1; dl_addr = 25'h15608; dl_data = 8'h5A;
        step();
        dl_addr = 25'h0C000; dl_data = 8'h11;
        step();
        chk("ld_ram_wr", ram_wr, 1);
        chk("ld_ram_addr", ram_addr, 16'h5608);
        chk("ld_ram_data", ram_data, 8'h5A);
        dl_wr = 0;
        step();
        chk("oob_rom_wr", rom_wr, 0);
        chk("oob_ram_wr", ram_wr, 0);

        // CPU holds the ports while the loader overfills the FIFO.
        cpu_wr = 1; cpu_addr = 16'h9000; cpu_data = 8'h33; rom_enabled = 0;
        for (int i = 0; i < 6; i++) begin
            dl_wr = (i < 5); dl_addr = 25'h100 + 25'(i); dl_data = 8'(8'hC0 + i);
            step();
            if (i == 3) chk("full_ready", ld_ready, 0);
            if (i == 4) chk("ovf_set", ld_overflow, 1);
        end
        cpu_wr = 0; dl_wr = 0;
        for (int k = 0; k < 4; k++) begin
            step();
            chk("drain_order", rom_addr, 15'h100 + 15'(k));
        end
        dl_active = 0;
        repeat (3) step();

        // ROM overlay drops low CPU addresses, upper ones still reach RAM.
        rom_enabled = 1; cpu_wr = 1; cpu_addr = 16'h1234; cpu_data = 8'h55;
        step();
        chk("cpu_drop_ram", ram_wr, 0);
        chk("cpu_drop_rom", rom_wr, 0);
        cpu_addr = 16'h9000; cpu_data = 8'h77;
        step();
        chk("cpu_hi_ram_wr", ram_wr, 1);
        chk("cpu_hi_addr", ram_addr, 16'h9000);
        chk("cpu_hi_data", ram_data, 8'h77);
        cpu_wr = 0; rom_enabled = 0;
        step();

        // Loader wins a simultaneous start; eraser strobes are then ignored.
        dl_active = 1; er_active = 1;
        step();
        chk("both_busy", busy, 1);
        er_wr = 1; er_addr = 25'h20; er_data = 8'h99;
        repeat (3) step();
        er_wr = 0;
        repeat (2) begin
            step();
            chk("er_ignored", rom_wr, 0);
        end
        dl_active = 0; er_active = 0;
        repeat (3) step();

        // Reset with entries queued discards them.
        dl_active = 1;
        step();
        cpu_wr = 1; cpu_addr = 16'hA000; cpu_data = 8'h01; dl_wr = 1;
        for (int i = 0; i < 3; i++) begin
            dl_addr = 25'h200 + 25'(i); dl_data = 8'(i);
            step();
        end
        cpu_wr = 0; dl_wr = 0; dl_active = 0; reset_n = 0;
        step();
        reset_n = 1;
        chk("rst_mid_busy", busy, 0);
        chk("rst_mid_ready", ld_ready, 1);
        repeat (4) begin
            step();
            chk("rst_mid_nowr", {rom_wr, ram_wr}, 0);
        end

        // Randomized traffic.
        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(0, 19) == 0) dl_active = ~dl_active;
            if ($urandom_range(0, 19) == 0) er_active = ~er_active;
            dl_wr = ($urandom_range(0, 1) != 0);
            er_wr = ($urandom_range(0, 1) != 0);
            dl_addr = rand_addr(); dl_data = 8'($urandom);
            er_addr = rand_addr(); er_data = 8'($urandom);
            cpu_wr = ($urandom_range(0, 3) == 0);
            cpu_addr = 16'($urandom); cpu_data = 8'($urandom);
            if ($urandom_range(0, 49) == 0) rom_enabled = ~rom_enabled;
            reset_n = ($urandom_range(0, 299) != 0);
            step();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
